// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and next-PC select encoding for the program counter unit
//
// Purpose: parameter defaults used by program_counter_unit and pc_return_stack,
//          plus the enum that names the next-PC source.
// Ports:   none (package)

package pc_pkg;

    localparam int PC_WIDTH_DEF     = 15;
    localparam int OFFSET_WIDTH_DEF = 8;
    localparam int JUMP_WIDTH_DEF   = 16;
    localparam int RAS_DEPTH_DEF    = 4;
    localparam int RESET_VECTOR_DEF = 0;

    typedef enum logic [1:0] {
        SEL_INC,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - circular return-address stack
//
// Purpose: LIFO of return addresses. A push into a full stack overwrites the
//          oldest entry and leaves the count saturated at RAS_DEPTH.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, pop       stack operations (pop wins if both are high; pop on empty is ignored)
//   data_in         address to push
//   top             most recently pushed valid entry
//   count           number of valid entries
//   full, empty     count == RAS_DEPTH / count == 0

module pc_return_stack
    import pc_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic [PC_WIDTH-1:0]              data_in,
    output logic [PC_WIDTH-1:0]              top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
    output logic                             full,
    output logic                             empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr_inc;
    logic                do_pop;
    logic                do_push;

    // wr_ptr is the next slot to write; the newest entry sits one below it.
    // Once the ring is full, wr_ptr also points at the oldest entry, so a
    // further push naturally overwrites it.
    assign rd_ptr     = (wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : wr_ptr - PTR_W'(1);
    assign wr_ptr_inc = (wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !do_pop;
    assign top     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (do_pop) begin
            wr_ptr <= rd_ptr;
            count  <= count - CNT_W'(1);
        end else if (do_push) begin
            wr_ptr <= wr_ptr_inc;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Entry contents need no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: rtl/program_counter_unit.sv
// rtl/program_counter_unit.sv - program counter with branch, jump, call/return stack and error flags
//
// Purpose: registered PC. Next-PC priority: ret, call/jump, branch, increment.
//          stall freezes the PC, the stack and the flags.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      hold all state this cycle
//   branch_sel, branch_offset  relative branch by a signed offset
//   jump_sel, jump_address     absolute jump (low PC_WIDTH bits of jump_address)
//   call, ret                  push return address and jump / pop into PC
//   clr_flags                  clear the sticky flags
//   pc                         current PC
//   ras_count                  valid stack entries
//   ras_overflow/underflow     sticky push-on-full / pop-on-empty flags

module program_counter_unit
    import pc_pkg::*;
#(
    parameter int          PC_WIDTH     = PC_WIDTH_DEF,
    parameter int          OFFSET_WIDTH = OFFSET_WIDTH_DEF,
    parameter int          JUMP_WIDTH   = JUMP_WIDTH_DEF,
    parameter int          RAS_DEPTH    = RAS_DEPTH_DEF,
    parameter int unsigned RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             stall,
    input  logic                             branch_sel,
    input  logic [OFFSET_WIDTH-1:0]          branch_offset,
    input  logic                             jump_sel,
    input  logic [JUMP_WIDTH-1:0]            jump_address,
    input  logic                             call,
    input  logic                             ret,
    input  logic                             clr_flags,
    output logic [PC_WIDTH-1:0]              pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ras_underflow
);

    pc_sel_e             sel;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_branch;
    logic [PC_WIDTH-1:0] pc_jump;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_full;
    logic                ras_empty;
    logic                push;
    logic                pop;
    logic                set_ovf;
    logic                set_unf;

    assign pc_inc    = pc + PC_WIDTH'(1);
    // Size cast of a signed operand sign-extends; the sum wraps modulo 2^PC_WIDTH.
    assign pc_branch = pc + PC_WIDTH'(signed'(branch_offset));
    // Truncating cast drops the upper jump_address bits.
    assign pc_jump   = PC_WIDTH'(jump_address);

    always_comb begin
        sel     = SEL_INC;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (!stall) begin
            if (ret) begin
                // Ret wins over a simultaneous call; an empty pop just increments.
                sel     = ras_empty ? SEL_INC : SEL_RET;
                pop     = !ras_empty;
                set_unf = ras_empty;
            end else if (call || jump_sel) begin
                sel     = SEL_JUMP;
                push    = call;
                set_ovf = call && ras_full;
            end else if (branch_sel) begin
                sel = SEL_BRANCH;
            end
        end
        case (sel)
            SEL_BRANCH: pc_next = pc_branch;
            SEL_JUMP:   pc_next = pc_jump;
            SEL_RET:    pc_next = ras_top;
            default:    pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= PC_WIDTH'(RESET_VECTOR);
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (!stall) begin
            pc <= pc_next;
            // A new error in the same cycle beats clr_flags.
            if (set_ovf) begin
                ras_overflow <= 1'b1;
            end else if (clr_flags) begin
                ras_overflow <= 1'b0;
            end
            if (set_unf) begin
                ras_underflow <= 1'b1;
            end else if (clr_flags) begin
                ras_underflow <= 1'b0;
            end
        end
    end

    pc_return_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .data_in (pc_inc),
        .top     (ras_top),
        .count   (ras_count),
        .full    (ras_full),
        .empty   (ras_empty)
    );

endmodule
